// File: rtl/instrumented_adder_pkg.sv
// Shared widths, register map and reset constants for the instrumented
// Brent-Kung adder ring and its Caravel wrapper.
package instrumented_adder_pkg;

  localparam int W     = 32;
  localparam int CNT_W = 32;

  localparam logic [2:0] ADDR_A    = 3'd0;
  localparam logic [2:0] ADDR_B    = 3'd1;
  localparam logic [2:0] ADDR_EXT  = 3'd2;
  localparam logic [2:0] ADDR_RING = 3'd3;
  localparam logic [2:0] ADDR_SOUT = 3'd4;
  localparam logic [2:0] ADDR_WIN  = 3'd5;

  localparam logic [W-1:0]     RST_A    = '0;
  localparam logic [W-1:0]     RST_B    = '0;
  localparam logic [W-1:0]     RST_EXT  = '0;
  localparam logic [W-1:0]     RST_RING = 32'h2000_0000;
  localparam logic [W-1:0]     RST_SOUT = '0;
  localparam logic [CNT_W-1:0] RST_WIN  = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_t;

endpackage

// File: rtl/instrumented_adder.sv
// Brent-Kung adder closed into a ring: the A operand is built from the
// loaded operand and the inverted loop output, and the masked OR of the
// sum is registered as chain_out while enabled.
module instrumented_adder
  import instrumented_adder_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a_input,
  input  logic [W-1:0] b_input,
  input  logic [W-1:0] a_input_ext_bit_b,
  input  logic [W-1:0] a_input_ring_bit_b,
  input  logic [W-1:0] s_output_bit_b,
  input  logic         en,
  output logic [W-1:0] sum,
  output logic         chain_out
);

  logic [W-1:0] a_eff;
  logic         chain_next;

  assign a_eff = (~a_input_ext_bit_b & a_input) |
                 (~a_input_ring_bit_b & {W{~chain_out}});

  // Brent-Kung prefix tree: up-sweep builds power-of-two spans, down-sweep fills the rest
  always_comb begin
    logic [W-1:0] g_t;
    logic [W-1:0] p_t;
    logic [W-1:0] prop;
    prop = a_eff ^ b_input;
    g_t  = a_eff & b_input;
    p_t  = prop;
    for (int d = 1; d < W; d = d * 2) begin
      for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
        g_t[i] = g_t[i] | (p_t[i] & g_t[i-d]);
        p_t[i] = p_t[i] & p_t[i-d];
      end
    end
    for (int d = W / 4; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
        g_t[i] = g_t[i] | (p_t[i] & g_t[i-d]);
        p_t[i] = p_t[i] & p_t[i-d];
      end
    end
    sum = prop ^ {g_t[W-2:0], 1'b0};
  end

  assign chain_next = |(sum & ~s_output_bit_b);

  // Loop register: advances only during a measurement window
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_out <= 1'b0;
    end else if (en) begin
      chain_out <= chain_next;
    end
  end

endmodule

// File: rtl/instrumented_adder_brent_wrap.sv
// Caravel user-project wrapper: LA register decode, run-window FSM,
// toggle counter and pad/LA output muxing around instrumented_adder.
// Build option: INACTIVE_TRISTATE_EN makes outputs 'z when active=0
// (otherwise they are driven 0).
module instrumented_adder_brent_wrap
  import instrumented_adder_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        active,
  input  logic [37:0] io_in,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  input  logic [31:0] la1_data_in,
  output logic [31:0] la1_data_out,
  input  logic [31:0] la1_oenb,
  input  logic [31:0] la2_data_in,
  output logic [31:0] la2_data_out,
  input  logic [31:0] la2_oenb,
  input  logic [31:0] la3_data_in,
  output logic [31:0] la3_data_out,
  input  logic [31:0] la3_oenb
);

  logic [W-1:0]     a_q, b_q, ext_q, ring_q, sout_q;
  logic [CNT_W-1:0] window_q, win_cnt_q, count_q;
  logic             wr_q, st_q;
  run_state_t       state_q, state_d;
  logic [W-1:0]     sum;
  logic             chain_out, chain_next, running, done;
  logic [2:0]       addr;
  logic [W-1:0]     wdata;
  logic             wr_sig, st_sig, wr_rise, st_rise;
  logic             unused_inputs;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign addr    = la1_data_in[2:0] & ~la1_oenb[2:0];
  assign wdata   = la2_data_in & ~la2_oenb;
  assign wr_sig  = la1_data_in[3] & ~la1_oenb[3];
  assign st_sig  = (la1_data_in[4] & ~la1_oenb[4]) | io_in[10];
  assign wr_rise = wr_sig & ~wr_q;
  assign st_rise = st_sig & ~st_q;
  assign running = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

  assign chain_next = |(sum & ~sout_q);

  assign unused_inputs = ^{la1_data_in[31:5], la1_oenb[31:5], la3_data_in,
                           la3_oenb, io_in[37:11], io_in[9:0]};

  instrumented_adder u_adder (
    .clk                (wb_clk_i),
    .rst                (wb_rst_i),
    .a_input            (a_q),
    .b_input            (b_q),
    .a_input_ext_bit_b  (ext_q),
    .a_input_ring_bit_b (ring_q),
    .s_output_bit_b     (sout_q),
    .en                 (running),
    .sum                (sum),
    .chain_out          (chain_out)
  );

  // Edge detectors for the LA write strobe and the combined start request
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_q <= 1'b0;
      st_q <= 1'b0;
    end else begin
      wr_q <= wr_sig;
      st_q <= st_sig;
    end
  end

  // Register file written on the strobe's rising edge; writes land even mid-run
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_q      <= RST_A;
      b_q      <= RST_B;
      ext_q    <= RST_EXT;
      ring_q   <= RST_RING;
      sout_q   <= RST_SOUT;
      window_q <= RST_WIN;
    end else if (wr_rise) begin
      case (addr)
        ADDR_A:    a_q      <= wdata;
        ADDR_B:    b_q      <= wdata;
        ADDR_EXT:  ext_q    <= wdata;
        ADDR_RING: ring_q   <= wdata;
        ADDR_SOUT: sout_q   <= wdata;
        ADDR_WIN:  window_q <= CNT_W'(wdata);
        default:   ;
      endcase
    end
  end

  // Run FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: a start outside RUN opens a window; a zero window finishes at once
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (win_cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      default: begin
        if (st_rise) state_d = (window_q == '0) ? ST_DONE : ST_RUN;
      end
    endcase
  end

  // Window down-counter and saturating rising-edge counter of the ring
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      win_cnt_q <= '0;
      count_q   <= '0;
    end else if (!running && st_rise) begin
      win_cnt_q <= window_q;
      count_q   <= '0;
    end else if (running) begin
      win_cnt_q <= win_cnt_q - 1'b1;
      if (!chain_out && chain_next) count_q <= sat_inc(count_q);
    end
  end

  // Output mux: isolate from pads and LA when not selected
  always_comb begin
    io_out       = '0;
    io_oeb       = '1;
    la1_data_out = '0;
    la2_data_out = '0;
    la3_data_out = '0;
    if (active) begin
      io_out[8]       = chain_out;
      io_out[9]       = done;
      io_oeb[9:8]     = 2'b00;
      la1_data_out[0] = running;
      la1_data_out[1] = done;
      la2_data_out    = sum;
      la3_data_out    = count_q;
    end else begin
`ifdef INACTIVE_TRISTATE_EN
      io_out       = 'z;
      io_oeb       = 'z;
      la1_data_out = 'z;
      la2_data_out = 'z;
      la3_data_out = 'z;
`else
      io_oeb       = '0;
`endif
    end
  end

endmodule

// File: tb/tb_instrumented_adder_brent_wrap.sv
// Scoreboard bench for instrumented_adder_brent_wrap: expected sums and
// toggle counts come from a behavioural model of the ring and are queued
// when stimulus is applied, then popped when the DUT result is observable.
module tb_instrumented_adder_brent_wrap;

  logic        clk = 1'b0;
  logic        rst;
  logic        active;
  logic [37:0] io_in;
  logic [37:0] io_out, io_oeb;
  logic [31:0] la1_in, la1_out, la1_oenb;
  logic [31:0] la2_in, la2_out, la2_oenb;
  logic [31:0] la3_in, la3_out, la3_oenb;

  int n_vec = 0;
  int n_err = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  logic [31:0] sa, sb, sext, sring, sout, swin;
  logic        schain;

  always #5 clk = ~clk;

  instrumented_adder_brent_wrap dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .active       (active),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_oeb       (io_oeb),
    .la1_data_in  (la1_in),
    .la1_data_out (la1_out),
    .la1_oenb     (la1_oenb),
    .la2_data_in  (la2_in),
    .la2_data_out (la2_out),
    .la2_oenb     (la2_oenb),
    .la3_data_in  (la3_in),
    .la3_data_out (la3_out),
    .la3_oenb     (la3_oenb)
  );

  task automatic check_vec(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_sum(input logic chain);
    return ((~sext & sa) | (~sring & {32{~chain}})) + sb;
  endfunction

  task automatic model_run(input int n, output logic [31:0] cnt);
    logic [31:0] s;
    logic        nx;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      s  = model_sum(schain);
      nx = |(s & ~sout);
      if (!schain && nx) cnt++;
      schain = nx;
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] got);
    string t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: got %h expected a queued value", got);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_vec(t, {8'h0, got}, {8'h0, e});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sa = 0; sb = 0; sext = 0; sring = 32'h2000_0000; sout = 0; swin = 0; schain = 0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    la1_in[2:0] = addr;
    la1_in[3]   = 1'b1;
    la2_in      = data;
    @(posedge clk); #1;
    la1_in[3]   = 1'b0;
    @(posedge clk); #1;
    case (addr)
      3'd0: sa = data;
      3'd1: sb = data;
      3'd2: sext = data;
      3'd3: sring = data;
      3'd4: sout = data;
      3'd5: swin = data;
      default: ;
    endcase
  endtask

  task automatic wr_chk(input string tag, input logic [2:0] addr, input logic [31:0] data);
    wr(addr, data);
    push_exp(tag, model_sum(schain));
    pop_cmp(la2_out);
  endtask

  task automatic do_run(input string tag, input bit via_io, input int restart_at);
    logic [31:0] cnt;
    int cyc;
    int n;
    n = int'(swin);
    model_run(n, cnt);
    push_exp(tag, cnt);
    if (via_io) io_in[10] = 1'b1;
    else        la1_in[4] = 1'b1;
    @(posedge clk); #1;
    io_in[10] = 1'b0;
    la1_in[4] = 1'b0;
    cyc = 0;
    while (la1_out[1] !== 1'b1 && cyc < 500) begin
      la1_in[4] = (cyc == restart_at);
      @(posedge clk); #1;
      cyc++;
    end
    la1_in[4] = 1'b0;
    check_vec({tag, "_cycles"}, 40'(cyc), 40'(n));
    check_vec({tag, "_status"}, {8'h0, la1_out}, 40'h2);
    check_vec({tag, "_io_out"}, {2'b0, io_out}, 40'h200 | (40'(schain) << 8));
    pop_cmp(la3_out);
  endtask

  initial begin
    rst = 1'b1; active = 1'b1; io_in = '0;
    la1_in = '0; la1_oenb = '0; la2_in = '0; la2_oenb = '0;
    la3_in = '0; la3_oenb = '0;
    do_reset();

    check_vec("rst_sum",    {8'h0, la2_out}, 40'hDF_FFFF_FFFF & 40'hFF_FFFF_FFFF & {8'h0, 32'hDFFF_FFFF});
    check_vec("rst_count",  {8'h0, la3_out}, 40'h0);
    check_vec("rst_status", {8'h0, la1_out}, 40'h0);
    check_vec("rst_io_out", {2'b0, io_out},  40'h0);
    check_vec("rst_io_oeb", {2'b0, io_oeb},  {2'b0, 28'hFFF_FFFF, 2'b00, 8'hFF});

    wr(3'd2, 32'h0);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd0, 32'd5);
    wr_chk("sum_5_3", 3'd1, 32'd3);
    wr(3'd0, 32'hFFFF_FFFF);
    wr_chk("sum_wrap", 3'd1, 32'hFFFF_FFFF);

    la1_oenb = 32'h8;
    wr(3'd0, 32'h1234);
    sa = 32'hFFFF_FFFF;
    la1_oenb = '0;
    push_exp("gated_write", model_sum(schain));
    pop_cmp(la2_out);
    wr_chk("addr6_ignored", 3'd6, 32'h0);
    wr_chk("ext_mask", 3'd2, 32'h0000_00FF);

    do_reset();
    wr(3'd5, 32'd10);
    do_run("run_w10", 1'b0, -1);

    wr(3'd5, 32'd0);
    do_run("run_w0", 1'b0, -1);

    wr(3'd5, 32'd10);
    do_run("run_restart", 1'b1, 3);

    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd0, 32'd1);
    wr(3'd5, 32'd4);
    do_run("run_const", 1'b0, -1);

    wr(3'd3, 32'h2000_0000);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd5, 32'd6);
    do_run("run_masked", 1'b1, -1);

    active = 1'b0;
    #1;
`ifdef INACTIVE_TRISTATE_EN
    check_vec("inact_io_out", {2'b0, io_out},  {2'b0, {38{1'bz}}});
    check_vec("inact_io_oeb", {2'b0, io_oeb},  {2'b0, {38{1'bz}}});
    check_vec("inact_la1",    {8'h0, la1_out}, {8'h0, {32{1'bz}}});
    check_vec("inact_la2",    {8'h0, la2_out}, {8'h0, {32{1'bz}}});
    check_vec("inact_la3",    {8'h0, la3_out}, {8'h0, {32{1'bz}}});
`else
    check_vec("inact_io_out", {2'b0, io_out},  40'h0);
    check_vec("inact_io_oeb", {2'b0, io_oeb},  40'h0);
    check_vec("inact_la1",    {8'h0, la1_out}, 40'h0);
    check_vec("inact_la2",    {8'h0, la2_out}, 40'h0);
    check_vec("inact_la3",    {8'h0, la3_out}, 40'h0);
`endif
    active = 1'b1;

    do_reset();
    wr(3'd5, 32'd100);
    la1_in[4] = 1'b1;
    @(posedge clk); #1;
    la1_in[4] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_vec("midrun_running", {8'h0, la1_out}, 40'h1);
    do_reset();
    check_vec("abort_status", {8'h0, la1_out}, 40'h0);
    check_vec("abort_count",  {8'h0, la3_out}, 40'h0);
    check_vec("abort_sum",    {8'h0, la2_out}, {8'h0, 32'hDFFF_FFFF});

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
